ioctl_load_sequencer: RTL

IOCTL_LOAD_SEQUENCER -- requirements
Module: ioctl_load_sequencer

---
 rtl/ioctl_load_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ioctl_load_sequencer.sv
// ioctl_load_sequencer
//   This module receives HPS ioctl downloads and routes each byte to one of
//   three places: the ROM write port, the game variant register (mod_sel) or
//   the DIP bank. It holds the game core in reset while a ROM load is running,
//   and for HOLD_CYCLES+1 cycles after the load ends.
//
//   Optional feature: define ROM_CHECKSUM_EN to add the rom_sum output. It is
//   the modulo-256 sum of the accepted ROM bytes. When enabled, rom_loaded is
//   only set if the sum equals EXPECTED_SUM.
//
// Ports
//   clk_25          single clock, rising edge
//   reset           asynchronous, active-high
//   ioctl_download  transfer active
//   ioctl_wr        one-cycle byte strobe
//   ioctl_index     transfer type (0 ROM, 1 mod select, 254 DIP)
//   ioctl_addr      byte address
//   ioctl_dout      byte data
//   rom_wr/addr/data  registered ROM write, one cycle after ioctl_wr
//   dip_sw          DIP bank, byte n at [8n+7:8n]
//   mod_sel         game variant code
//   core_reset      game core reset (reset, ROM load, post-load hold)
//   rom_loaded      last ROM load was complete
//   rom_short       last ROM load delivered fewer than ROM_SIZE bytes
//   rom_sum         (ROM_CHECKSUM_EN only) running byte sum
module ioctl_load_sequencer #(
  parameter int unsigned ROM_SIZE     = 65536,
  parameter int unsigned HOLD_CYCLES  = 1024,
  parameter logic [7:0]  EXPECTED_SUM = 8'h00
) (
  input  logic        clk_25,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        rom_wr,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic [63:0] dip_sw,
  output logic [7:0]  mod_sel,
  output logic        core_reset,
  output logic        rom_loaded,
  output logic        rom_short
`ifdef ROM_CHECKSUM_EN
  ,
  output logic [7:0]  rom_sum
`endif
);

  localparam int          HW          = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [16:0] ROM_CNT_MAX = 17'(ROM_SIZE);

  typedef enum logic [2:0] {S_IDLE, S_ROM, S_MOD, S_DIP, S_HOLD} state_t;

  state_t        state;
  logic          dl_q;
  logic [16:0]   cnt;
  logic [HW-1:0] hold_cnt;

  logic        dl_rise, dl_fall, rom_accept, load_ok;
  logic [16:0] cnt_next;

  assign dl_rise    = ioctl_download & ~dl_q;
  assign dl_fall    = ~ioctl_download & dl_q;
  assign rom_accept = (state == S_ROM) && ioctl_wr && (32'(ioctl_addr) < ROM_SIZE);
  assign cnt_next   = (rom_accept && (cnt != ROM_CNT_MAX)) ? cnt + 17'd1 : cnt;

`ifdef ROM_CHECKSUM_EN
  logic [7:0] sum_next;
  assign sum_next = rom_accept ? rom_sum + ioctl_dout : rom_sum;
  assign load_ok  = (cnt_next == ROM_CNT_MAX) && (sum_next == EXPECTED_SUM);
`else
  logic [7:0] unused_expected_sum;
  assign unused_expected_sum = EXPECTED_SUM;
  assign load_ok = (cnt_next == ROM_CNT_MAX);
`endif

  assign core_reset = reset | (state == S_ROM) | (state == S_HOLD);

  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      // Preset high so that a download still held high when reset is
      // released is not seen as a new rising edge.
      dl_q       <= 1'b1;
      cnt        <= '0;
      hold_cnt   <= '0;
      rom_wr     <= 1'b0;
      rom_addr   <= '0;
      rom_data   <= '0;
      dip_sw     <= '0;
      mod_sel    <= '0;
      rom_loaded <= 1'b0;
      rom_short  <= 1'b0;
`ifdef ROM_CHECKSUM_EN
      rom_sum    <= '0;
`endif
    end else begin
      dl_q   <= ioctl_download;
      rom_wr <= 1'b0;
      case (state)
        S_IDLE: begin
          // The index is sampled only here. A later change to it is ignored.
          if (dl_rise) begin
            case (ioctl_index)
              8'd0: begin
                state      <= S_ROM;
                cnt        <= '0;
                rom_loaded <= 1'b0;
                rom_short  <= 1'b0;
`ifdef ROM_CHECKSUM_EN
                rom_sum    <= '0;
`endif
              end
              8'd1:    state <= S_MOD;
              8'd254:  state <= S_DIP;
              default: state <= S_IDLE;
            endcase
          end
        end
        S_ROM: begin
          // A write in the same cycle as the falling edge is still taken
          // and counted, so cnt_next is used for the completion check.
          if (rom_accept) begin
            rom_wr   <= 1'b1;
            rom_addr <= ioctl_addr[15:0];
            rom_data <= ioctl_dout;
          end
          cnt <= cnt_next;
`ifdef ROM_CHECKSUM_EN
          rom_sum <= sum_next;
`endif
          if (dl_fall) begin
            state      <= S_HOLD;
            hold_cnt   <= HW'(HOLD_CYCLES);
            rom_loaded <= load_ok;
            rom_short  <= (cnt_next != ROM_CNT_MAX);
          end
        end
        S_MOD: begin
          if (ioctl_wr) mod_sel <= ioctl_dout;
          if (dl_fall)  state   <= S_IDLE;
        end
        S_DIP: begin
          if (ioctl_wr && (ioctl_addr[24:3] == '0))
            dip_sw[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
          if (dl_fall) state <= S_IDLE;
        end
        S_HOLD: begin
          if (hold_cnt == '0) state <= S_IDLE;
          else                hold_cnt <= hold_cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
